// File: rtl/freq2trig_seq.sv
// Sequential frequency-to-coefficient converter: folds a frequency request onto a
// shared quarter-wave cosine table and returns the signed (cos, sin) pair per channel.
module freq2trig_seq #(
  parameter  int WL  = 16,
  parameter  int FW  = 8,
  parameter  int NQ  = 120,
  parameter  int NCH = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FW-1:0]        req_freq_i,
  input  logic [CW-1:0]        req_ch_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CW-1:0]        out_ch_o,
  output logic signed [WL-1:0] cos_out_o,
  output logic signed [WL-1:0] sin_out_o,
  output logic                 out_err_o
);

  localparam int IW = FW + 1;
  localparam int AW = (NQ > 0) ? $clog2(NQ + 1) : 1;
  localparam logic [IW-1:0] NQ_I  = IW'(NQ);
  localparam logic [IW-1:0] NQ2_I = IW'(2 * NQ);

  typedef enum logic [2:0] {IDLE, FOLD, RD_COS, RD_SIN, HOLD} state_t;

  // Elaboration-time cosine entry, Taylor series over [0, pi/2], truncated toward zero.
  function automatic logic signed [WL-1:0] tbl_entry(input int i);
    real x, term, sum, v;
    x    = 3.14159265358979323846 * real'(i) / (2.0 * real'(NQ));
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k <= 30; k++) begin
      term = -term * x * x / (real'(2 * k - 1) * real'(2 * k));
      sum  = sum + term;
    end
    v = sum * (2.0 ** (WL - 1));
    if (i == 0)
      return {1'b0, {(WL-1){1'b1}}};
    else if (i == NQ)
      return '0;
    else
      return WL'($rtoi(v));
  endfunction

  logic signed [WL-1:0] rom [0:NQ];
  for (genvar g = 0; g <= NQ; g++) begin : g_rom
    localparam logic signed [WL-1:0] V = tbl_entry(g);
    assign rom[g] = V;
  end

  state_t               state_q, state_d;
  logic [FW-1:0]        freq_q, freq_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [AW-1:0]        is_q, is_d;
  logic                 nc_q, nc_d;
  logic                 err_q, err_d;
  logic signed [WL-1:0] cos_q, cos_d;
  logic signed [WL-1:0] sin_q, sin_d;
  logic [CW-1:0]        och_q, och_d;
  logic                 oerr_q, oerr_d;
  logic                 vld_q, vld_d;

  logic signed [WL-1:0] rd_data;
  logic [IW-1:0]        f_w, ic_w, is_w;
  logic                 nc_w, err_w;

  assign rd_data = rom[rd_addr_q];

  // Fold the angle 0..pi onto the quarter table; out-of-range requests map to angle 0.
  always_comb begin
    f_w   = {1'b0, freq_q};
    ic_w  = '0;
    is_w  = NQ_I;
    nc_w  = 1'b0;
    err_w = 1'b0;
    if (f_w <= NQ_I) begin
      ic_w = f_w;
      is_w = NQ_I - f_w;
    end else if (f_w <= NQ2_I) begin
      ic_w = NQ2_I - f_w;
      is_w = f_w - NQ_I;
      nc_w = 1'b1;
    end else begin
      err_w = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    ch_d      = ch_q;
    rd_addr_d = rd_addr_q;
    is_d      = is_q;
    nc_d      = nc_q;
    err_d     = err_q;
    cos_d     = cos_q;
    sin_d     = sin_q;
    och_d     = och_q;
    oerr_d    = oerr_q;
    vld_d     = vld_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          freq_d  = req_freq_i;
          ch_d    = req_ch_i;
          state_d = FOLD;
        end
      end
      FOLD: begin
        rd_addr_d = AW'(ic_w);
        is_d      = AW'(is_w);
        nc_d      = nc_w;
        err_d     = err_w;
        state_d   = RD_COS;
      end
      RD_COS: begin
        cos_d     = nc_q ? -rd_data : rd_data;
        rd_addr_d = is_q;
        state_d   = RD_SIN;
      end
      RD_SIN: begin
        sin_d   = rd_data;
        och_d   = ch_q;
        oerr_d  = err_q;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      freq_q    <= '0;
      ch_q      <= '0;
      rd_addr_q <= '0;
      is_q      <= '0;
      nc_q      <= 1'b0;
      err_q     <= 1'b0;
      cos_q     <= '0;
      sin_q     <= '0;
      och_q     <= '0;
      oerr_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      ch_q      <= ch_d;
      rd_addr_q <= rd_addr_d;
      is_q      <= is_d;
      nc_q      <= nc_d;
      err_q     <= err_d;
      cos_q     <= cos_d;
      sin_q     <= sin_d;
      och_q     <= och_d;
      oerr_q    <= oerr_d;
      vld_q     <= vld_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign out_valid_o = vld_q;
  assign out_ch_o    = och_q;
  assign cos_out_o   = cos_q;
  assign sin_out_o   = sin_q;
  assign out_err_o   = oerr_q;

endmodule

// File: tb/tb_freq2trig_seq.sv
// Directed bench for freq2trig_seq: default build plus a reduced WL=12/NQ=60 build.
module tb_freq2trig_seq;

  logic clk;
  logic rst_n;

  logic              req_valid, req_ready, out_valid, out_ready, out_err;
  logic [7:0]        req_freq;
  logic [1:0]        req_ch, out_ch;
  logic signed [15:0] cos_out, sin_out;

  logic              s_req_valid, s_req_ready, s_out_valid, s_out_ready, s_out_err;
  logic [7:0]        s_req_freq;
  logic [1:0]        s_req_ch, s_out_ch;
  logic signed [11:0] s_cos_out, s_sin_out;

  int checks;
  int errors;

  freq2trig_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_freq_i(req_freq), .req_ch_i(req_ch),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ch_o(out_ch), .cos_out_o(cos_out), .sin_out_o(sin_out),
    .out_err_o(out_err)
  );

  freq2trig_seq #(.WL(12), .FW(8), .NQ(60), .NCH(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
    .req_freq_i(s_req_freq), .req_ch_i(s_req_ch),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_ch_o(s_out_ch), .cos_out_o(s_cos_out), .sin_out_o(s_sin_out),
    .out_err_o(s_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int f, input int ch, input int ec, input int es,
                        input int ee, input string nm);
    int n;
    n = 0;
    req_freq  = 8'(f);
    req_ch    = 2'(ch);
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    req_freq  = 8'hAA;
    req_ch    = 2'(~ch);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (out_valid !== (i == 3)) begin
        errors++;
        $display("FAIL %s latency cycle %0d: out_valid=%b required %b", nm, i, out_valid, (i == 3));
      end
    end
    checks++;
    if (cos_out !== 16'(ec)) begin
      errors++;
      $display("FAIL %s cos: got %0d required %0d", nm, cos_out, ec);
    end
    checks++;
    if (sin_out !== 16'(es)) begin
      errors++;
      $display("FAIL %s sin: got %0d required %0d", nm, sin_out, es);
    end
    checks++;
    if (out_ch !== 2'(ch)) begin
      errors++;
      $display("FAIL %s ch: got %0d required %0d", nm, out_ch, ch);
    end
    checks++;
    if (out_err !== 1'(ee)) begin
      errors++;
      $display("FAIL %s err: got %b required %0d", nm, out_err, ee);
    end
    if (out_ready) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s consume: out_valid=%b req_ready=%b required 0/1", nm, out_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || cos_out !== 16'sd0 || sin_out !== 16'sd0 ||
        out_ch !== 2'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: vld=%b cos=%0d sin=%0d ch=%0d err=%b required all 0",
               out_valid, cos_out, sin_out, out_ch, out_err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset ready: got %b required 1", req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first();
    do_req(0, 2, 32767, 0, 0, "f0");
  endtask

  task automatic test_sweep();
    do_req(60, 0, 23170, 23170, 0, "f60");
    do_req(120, 1, 0, 32767, 0, "f120");
    do_req(180, 2, -23170, 23170, 0, "f180");
    do_req(240, 3, -32767, 0, 0, "f240");
  endtask

  task automatic test_range();
    do_req(241, 1, 32767, 0, 1, "f241");
    do_req(255, 3, 32767, 0, 1, "f255");
    do_req(1, 0, 32765, 428, 0, "f1");
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    do_req(60, 1, 23170, 23170, 0, "stall");
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_freq  = 8'd5;
      req_ch    = 2'd3;
      tick();
      checks++;
      if (out_valid !== 1'b1 || cos_out !== 16'sd23170 || sin_out !== 16'sd23170 ||
          out_ch !== 2'd1 || out_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall hold %0d: vld=%b cos=%0d sin=%0d ch=%0d err=%b rdy=%b required 1/23170/23170/1/0/0",
                 i, out_valid, cos_out, sin_out, out_ch, out_err, req_ready);
      end
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall release: vld=%b rdy=%b required 0/1", out_valid, req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall ignored req %0d: vld=%b rdy=%b required 0/1", i, out_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset_midop();
    req_freq  = 8'd180;
    req_ch    = 2'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cos_out !== 16'sd0 || sin_out !== 16'sd0 ||
        out_ch !== 2'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL midop reset outputs: vld=%b cos=%0d sin=%0d ch=%0d err=%b required all 0",
               out_valid, cos_out, sin_out, out_ch, out_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL midop stale %0d: vld=%b rdy=%b required 0/1", i, out_valid, req_ready);
      end
    end
    do_req(120, 2, 0, 32767, 0, "post_reset");
  endtask

  task automatic test_small_table();
    int fv [2];
    int ec [2];
    int es [2];
    int n;
    fv = '{30, 60};
    ec = '{1448, 0};
    es = '{1448, 2047};
    for (int k = 0; k < 2; k++) begin
      n = 0;
      s_req_freq  = 8'(fv[k]);
      s_req_ch    = 2'(k + 1);
      s_req_valid = 1'b1;
      while (!s_req_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
      s_req_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (s_out_valid !== 1'b1 || n != 3) begin
        errors++;
        $display("FAIL small f%0d latency: vld=%b cycles=%0d required 1/3", fv[k], s_out_valid, n);
      end
      checks++;
      if (s_cos_out !== 12'(ec[k]) || s_sin_out !== 12'(es[k]) || s_out_ch !== 2'(k + 1)) begin
        errors++;
        $display("FAIL small f%0d values: cos=%0d sin=%0d ch=%0d required %0d/%0d/%0d",
                 fv[k], s_cos_out, s_sin_out, s_out_ch, ec[k], es[k], k + 1);
      end
      tick();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    req_valid   = 1'b0;
    req_freq    = 8'd0;
    req_ch      = 2'd0;
    out_ready   = 1'b1;
    s_req_valid = 1'b0;
    s_req_freq  = 8'd0;
    s_req_ch    = 2'd0;
    s_out_ready = 1'b1;
    test_reset();
    test_first();
    test_sweep();
    test_range();
    test_stall();
    test_reset_midop();
    test_small_table();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
